// File: rtl/pe_test_pkg.sv
// Shared types and sizing helpers for the PE-slot loopback test engine.
// Mode encoding matches the bm2pe_mode port values.
package pe_test_pkg;

  typedef enum logic [1:0] {
    MODE_PACK    = 2'd0,
    MODE_PATTERN = 2'd1,
    MODE_SUM     = 2'd2,
    MODE_INVERT  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int wpl(input int rbbWidth, input int tbbWidth);
    return rbbWidth / tbbWidth;
  endfunction

  // Ceiling log2, never below 1 so counters always have at least one bit.
  function automatic int log2c(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/tbb_line_packer.sv
// Tags returning TBB words with a valid delay line and assembles them into
// RBB lines, applying the PACK / SUM / INVERT transform on the final word.
module tbb_line_packer
  import pe_test_pkg::*;
#(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int TBB_RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_clear,
  input  logic                      i_issue,
  input  mode_t                     i_mode,
  input  logic [TBB_DATA_WIDTH-1:0] i_rdData,
  output logic                      o_lineReady,
  output logic [RBB_DATA_WIDTH-1:0] o_line
);

  localparam int WPL = wpl(RBB_DATA_WIDTH, TBB_DATA_WIDTH);
  localparam int WCW = log2c(WPL);

  logic [TBB_RD_LATENCY-1:0] r_vldPipe;
  logic [WCW-1:0]            r_wordCnt;
  logic [RBB_DATA_WIDTH-1:0] r_shift;
  logic [TBB_DATA_WIDTH-1:0] r_sum;

  logic                      w_wordValid;
  logic                      w_lastWord;
  logic [RBB_DATA_WIDTH-1:0] w_packed;
  logic [TBB_DATA_WIDTH-1:0] w_sum;

  // The line is emitted combinationally with the last word so the top-level
  // write register lands one cycle after that word returns.
  always_comb begin
    w_wordValid = r_vldPipe[TBB_RD_LATENCY-1];
    w_lastWord  = (r_wordCnt == WCW'(WPL - 1));
    w_packed    = (r_shift >> TBB_DATA_WIDTH)
                | (RBB_DATA_WIDTH'(i_rdData) << (RBB_DATA_WIDTH - TBB_DATA_WIDTH));
    w_sum       = r_sum + i_rdData;
    o_lineReady = w_wordValid && w_lastWord;
    case (i_mode)
      MODE_INVERT: o_line = ~w_packed;
      MODE_SUM:    o_line = RBB_DATA_WIDTH'(w_sum);
      default:     o_line = w_packed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_vldPipe <= '0;
      r_wordCnt <= '0;
      r_shift   <= '0;
      r_sum     <= '0;
    end else begin
      r_vldPipe <= (r_vldPipe << 1) | TBB_RD_LATENCY'(i_issue);
      if (w_wordValid) begin
        r_shift   <= w_packed;
        r_sum     <= w_lastWord ? '0 : w_sum;
        r_wordCnt <= w_lastWord ? '0 : r_wordCnt + WCW'(1);
      end
    end
  end

endmodule

// File: rtl/pe_loopback_array.sv
// PE-slot test engine: streams TBB words, packs or transforms them into RBB
// lines (or writes a counting pattern) and signals completion to the BM.
module pe_loopback_array
  import pe_test_pkg::*;
#(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int TBB_ADDR_WIDTH = 16,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int RBB_ADDR_WIDTH = 8,
  parameter int TBB_RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      bm2pe_start,
  input  logic [1:0]                bm2pe_mode,
  input  logic [RBB_ADDR_WIDTH:0]   bm2pe_numLines,
  output logic                      pe2bm_busy,
  output logic                      pe2bm_done,
  output logic                      pe2bm_rbbWrEn,
  output logic [RBB_ADDR_WIDTH-1:0] pe2bm_rbbWrAddr,
  output logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbWrDin,
  output logic [TBB_ADDR_WIDTH-1:0] pe2bm_tbbRdAddr,
  input  logic [TBB_DATA_WIDTH-1:0] bm2pe_tbbRdDout
);

  localparam int WPL      = wpl(RBB_DATA_WIDTH, TBB_DATA_WIDTH);
  localparam int LCW      = RBB_ADDR_WIDTH + 1;
  localparam int RD_CNT_W = RBB_ADDR_WIDTH + 1 + log2c(WPL);

  state_t                    r_state;
  mode_t                     r_mode;
  logic [LCW-1:0]            r_numLines;
  logic [LCW-1:0]            r_lineCnt;
  logic [RD_CNT_W-1:0]       r_rdCnt;
  logic [RD_CNT_W-1:0]       r_lastRd;
  logic                      r_wrEn;
  logic [RBB_ADDR_WIDTH-1:0] r_wrAddr;
  logic [RBB_DATA_WIDTH-1:0] r_wrDin;

  state_t                    w_nextState;
  mode_t                     w_startMode;
  logic                      w_accept;
  logic                      w_patMode;
  logic                      w_linesDone;
  logic                      w_lastRead;
  logic                      w_issue;
  logic                      w_lineReady;
  logic [RBB_DATA_WIDTH-1:0] w_line;

  // Completion is judged on lines issued, which covers both the pattern
  // path and draining the read pipeline in FLUSH.
  always_comb begin
    w_startMode = mode_t'(bm2pe_mode);
    w_accept    = (r_state == ST_IDLE) && bm2pe_start;
    w_patMode   = (r_mode == MODE_PATTERN);
    w_linesDone = (r_lineCnt == r_numLines);
    w_lastRead  = (r_rdCnt == r_lastRd);
    w_issue     = (r_state == ST_READ) && !w_patMode;
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nextState = (bm2pe_numLines == '0) ? ST_DONE : ST_READ;
      ST_READ: begin
        if (w_patMode) begin
          if (w_linesDone) w_nextState = ST_DONE;
        end else if (w_lastRead) begin
          w_nextState = ST_FLUSH;
        end
      end
      ST_FLUSH: if (w_linesDone) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_PACK;
      r_numLines <= '0;
      r_lineCnt  <= '0;
      r_rdCnt    <= '0;
      r_lastRd   <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrDin    <= '0;
    end else begin
      r_state <= w_nextState;
      r_wrEn  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode     <= w_startMode;
            r_numLines <= bm2pe_numLines;
            r_lastRd   <= RD_CNT_W'(bm2pe_numLines) * RD_CNT_W'(WPL) - RD_CNT_W'(1);
            r_rdCnt    <= '0;
            r_lineCnt  <= '0;
            // Pattern line 0 goes out in cycle 1, so it is issued at accept.
            if (w_startMode == MODE_PATTERN && bm2pe_numLines != '0) begin
              r_wrEn    <= 1'b1;
              r_wrAddr  <= '0;
              r_wrDin   <= '0;
              r_lineCnt <= LCW'(1);
            end
          end
        end
        ST_READ: begin
          if (w_patMode && !w_linesDone) begin
            r_wrEn    <= 1'b1;
            r_wrAddr  <= r_lineCnt[RBB_ADDR_WIDTH-1:0];
            r_wrDin   <= RBB_DATA_WIDTH'(r_lineCnt);
            r_lineCnt <= r_lineCnt + LCW'(1);
          end
          if (w_issue) r_rdCnt <= w_lastRead ? '0 : r_rdCnt + RD_CNT_W'(1);
        end
        ST_DONE: begin
          r_rdCnt   <= '0;
          r_wrAddr  <= '0;
          r_lineCnt <= '0;
        end
        default: ;
      endcase
      if (w_lineReady) begin
        r_wrEn    <= 1'b1;
        r_wrAddr  <= r_lineCnt[RBB_ADDR_WIDTH-1:0];
        r_wrDin   <= w_line;
        r_lineCnt <= r_lineCnt + LCW'(1);
      end
    end
  end

  tbb_line_packer #(
    .TBB_DATA_WIDTH (TBB_DATA_WIDTH),
    .RBB_DATA_WIDTH (RBB_DATA_WIDTH),
    .TBB_RD_LATENCY (TBB_RD_LATENCY)
  ) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (r_state == ST_IDLE),
    .i_issue     (w_issue),
    .i_mode      (r_mode),
    .i_rdData    (bm2pe_tbbRdDout),
    .o_lineReady (w_lineReady),
    .o_line      (w_line)
  );

  assign pe2bm_busy      = (r_state == ST_READ) || (r_state == ST_FLUSH);
  assign pe2bm_done      = (r_state == ST_DONE);
  assign pe2bm_rbbWrEn   = r_wrEn;
  assign pe2bm_rbbWrAddr = r_wrAddr;
  assign pe2bm_rbbWrDin  = r_wrDin;
  assign pe2bm_tbbRdAddr = TBB_ADDR_WIDTH'(r_rdCnt);

endmodule

// File: tb/tb_pe_loopback_array.sv
// Directed bench for pe_loopback_array: one instance at read latency 1 and
// one at latency 3, both fed by behavioural TBB models.
module tb_pe_loopback_array;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [1:0]   mode;
  logic [8:0]   numLines;
  logic         fillOnes;

  logic         busyA, doneA, wrEnA;
  logic [7:0]   wrAddrA;
  logic [511:0] wrDinA;
  logic [15:0]  rdAddrA;
  logic [31:0]  doutA;

  logic         busyB, doneB, wrEnB;
  logic [7:0]   wrAddrB;
  logic [511:0] wrDinB;
  logic [15:0]  rdAddrB;
  logic [31:0]  doutB;
  logic [31:0]  pipeB0, pipeB1;

  logic         sel;
  logic         obBusy, obDone, obWrEn;
  logic [7:0]   obWrAddr;
  logic [511:0] obWrDin;
  logic [15:0]  obRdAddr;

  int           checks;
  int           errors;
  logic [511:0] capDin[$];
  logic [7:0]   capAddr[$];
  int           capCyc[$];
  int           doneCyc;
  int           backToBack;
  int           rdNonZero;
  logic         busyAt1;

  pe_loopback_array #(.TBB_RD_LATENCY(1)) dutA (
    .clk(clk), .reset_n(reset_n), .bm2pe_start(start), .bm2pe_mode(mode),
    .bm2pe_numLines(numLines), .pe2bm_busy(busyA), .pe2bm_done(doneA),
    .pe2bm_rbbWrEn(wrEnA), .pe2bm_rbbWrAddr(wrAddrA), .pe2bm_rbbWrDin(wrDinA),
    .pe2bm_tbbRdAddr(rdAddrA), .bm2pe_tbbRdDout(doutA)
  );

  pe_loopback_array #(.TBB_RD_LATENCY(3)) dutB (
    .clk(clk), .reset_n(reset_n), .bm2pe_start(start), .bm2pe_mode(mode),
    .bm2pe_numLines(numLines), .pe2bm_busy(busyB), .pe2bm_done(doneB),
    .pe2bm_rbbWrEn(wrEnB), .pe2bm_rbbWrAddr(wrAddrB), .pe2bm_rbbWrDin(wrDinB),
    .pe2bm_tbbRdAddr(rdAddrB), .bm2pe_tbbRdDout(doutB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tbbWord(input logic [15:0] addr);
    return fillOnes ? 32'hFFFF_FFFF : 32'(addr);
  endfunction

  // TBB models: data for an address driven in cycle c appears in cycle c+L.
  always @(posedge clk) begin
    doutA  <= tbbWord(rdAddrA);
    pipeB0 <= tbbWord(rdAddrB);
    pipeB1 <= pipeB0;
    doutB  <= pipeB1;
  end

  always_comb begin
    if (sel) begin
      obBusy = busyB; obDone = doneB; obWrEn = wrEnB;
      obWrAddr = wrAddrB; obWrDin = wrDinB; obRdAddr = rdAddrB;
    end else begin
      obBusy = busyA; obDone = doneA; obWrEn = wrEnA;
      obWrAddr = wrAddrA; obWrDin = wrDinA; obRdAddr = rdAddrA;
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] dinAt(input int i);
    return (i < capDin.size()) ? capDin[i] : 'x;
  endfunction

  function automatic logic [7:0] addrAt(input int i);
    return (i < capAddr.size()) ? capAddr[i] : 'x;
  endfunction

  function automatic int cycAt(input int i);
    return (i < capCyc.size()) ? capCyc[i] : -1;
  endfunction

  function automatic logic [511:0] expLine(input int base, input bit inv);
    logic [511:0] line;
    logic [31:0]  w;
    line = '0;
    for (int j = 0; j < 16; j++) begin
      w = 32'(base + j);
      line[j*32 +: 32] = inv ? ~w : w;
    end
    return line;
  endfunction

  // Starts one operation and records writes, reads and the done cycle,
  // numbering cycles so that the start-sampling cycle is cycle 0.
  task automatic applyStimulus(input logic selIn, input logic [1:0] m, input int n,
                               input int budget, input int glitchAt, input int abortAt);
    logic prevWr;
    sel = selIn;
    capDin.delete(); capAddr.delete(); capCyc.delete();
    doneCyc = -1; backToBack = 0; rdNonZero = 0; busyAt1 = 1'b0; prevWr = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; numLines = 9'(n);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc == 1) busyAt1 = obBusy;
      if (obWrEn) begin
        capDin.push_back(obWrDin);
        capAddr.push_back(obWrAddr);
        capCyc.push_back(cyc);
      end
      if (obWrEn && prevWr) backToBack++;
      prevWr = obWrEn;
      if (obRdAddr != 16'd0) rdNonZero++;
      if (obDone) begin
        doneCyc = cyc;
        break;
      end
      if (cyc == abortAt) break;
      if (cyc == glitchAt) begin
        start = 1'b1; mode = 2'd1; numLines = 9'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    checks = 0; errors = 0; sel = 1'b0;
    reset_n = 1'b0; start = 1'b0; mode = 2'd0; numLines = 9'd0; fillOnes = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   512'(obBusy),   512'(0));
    checkOutput("rst_done",   512'(obDone),   512'(0));
    checkOutput("rst_wrEn",   512'(obWrEn),   512'(0));
    checkOutput("rst_wrAddr", 512'(obWrAddr), 512'(0));
    checkOutput("rst_wrDin",  obWrDin,        512'(0));
    checkOutput("rst_rdAddr", 512'(obRdAddr), 512'(0));
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] PACK numLines=2 latency 1");
    applyStimulus(1'b0, 2'd0, 2, 100, -1, -1);
    checkOutput("pack_busy1",  512'(busyAt1),       512'(1));
    checkOutput("pack_nwr",    512'(capDin.size()), 512'(2));
    checkOutput("pack_cyc0",   512'(cycAt(0)),      512'(18));
    checkOutput("pack_cyc1",   512'(cycAt(1)),      512'(34));
    checkOutput("pack_addr0",  512'(addrAt(0)),     512'(0));
    checkOutput("pack_addr1",  512'(addrAt(1)),     512'(1));
    checkOutput("pack_line0",  dinAt(0),            expLine(0, 1'b0));
    checkOutput("pack_line1",  dinAt(1),            expLine(16, 1'b0));
    checkOutput("pack_done",   512'(doneCyc),       512'(35));
    checkOutput("pack_b2b",    512'(backToBack),    512'(0));

    $display("[TB] SUM numLines=1 all-ones data");
    fillOnes = 1'b1;
    applyStimulus(1'b0, 2'd2, 1, 100, -1, -1);
    fillOnes = 1'b0;
    checkOutput("sum_nwr",  512'(capDin.size()), 512'(1));
    checkOutput("sum_cyc",  512'(cycAt(0)),      512'(18));
    checkOutput("sum_line", dinAt(0),            512'(32'hFFFF_FFF0));
    checkOutput("sum_done", 512'(doneCyc),       512'(19));

    $display("[TB] PATTERN numLines=256");
    applyStimulus(1'b0, 2'd1, 256, 400, -1, -1);
    checkOutput("pat_nwr",    512'(capDin.size()), 512'(256));
    checkOutput("pat_first",  512'(cycAt(0)),      512'(1));
    checkOutput("pat_last",   512'(cycAt(255)),    512'(256));
    checkOutput("pat_done",   512'(doneCyc),       512'(257));
    checkOutput("pat_reads",  512'(rdNonZero),     512'(0));
    for (int k = 0; k < 256; k++) begin
      checkOutput($sformatf("pat_addr%0d", k), 512'(addrAt(k)), 512'(k));
      checkOutput($sformatf("pat_line%0d", k), dinAt(k),        512'(k));
    end
    @(negedge clk);
    checkOutput("pat_addrwrap", 512'(obWrAddr), 512'(0));

    $display("[TB] numLines=0");
    applyStimulus(1'b0, 2'd0, 0, 20, -1, -1);
    checkOutput("zero_done",  512'(doneCyc),       512'(1));
    checkOutput("zero_nwr",   512'(capDin.size()), 512'(0));
    checkOutput("zero_reads", 512'(rdNonZero),     512'(0));

    $display("[TB] INVERT numLines=1 with ignored start during busy");
    applyStimulus(1'b0, 2'd3, 1, 100, 5, -1);
    checkOutput("inv_nwr",  512'(capDin.size()), 512'(1));
    checkOutput("inv_cyc",  512'(cycAt(0)),      512'(18));
    checkOutput("inv_line", dinAt(0),            expLine(0, 1'b1));
    checkOutput("inv_done", 512'(doneCyc),       512'(19));
    repeat (3) @(negedge clk);
    checkOutput("inv_idle", 512'(obBusy),        512'(0));

    $display("[TB] PACK numLines=1 latency 3");
    applyStimulus(1'b1, 2'd0, 1, 100, -1, -1);
    checkOutput("lat3_nwr",  512'(capDin.size()), 512'(1));
    checkOutput("lat3_cyc",  512'(cycAt(0)),      512'(20));
    checkOutput("lat3_line", dinAt(0),            expLine(0, 1'b0));
    checkOutput("lat3_done", 512'(doneCyc),       512'(21));

    $display("[TB] reset mid-operation then fresh start, latency 3");
    applyStimulus(1'b1, 2'd0, 1, 100, -1, 10);
    reset_n = 1'b0;
    doneSeen = 0;
    @(negedge clk);
    checkOutput("abort_busy",   512'(obBusy),   512'(0));
    checkOutput("abort_wrEn",   512'(obWrEn),   512'(0));
    checkOutput("abort_wrAddr", 512'(obWrAddr), 512'(0));
    checkOutput("abort_wrDin",  obWrDin,        512'(0));
    checkOutput("abort_rdAddr", 512'(obRdAddr), 512'(0));
    for (int i = 0; i < 12; i++) begin
      if (obDone) doneSeen++;
      if (i == 1) reset_n = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort_nodone", 512'(doneSeen), 512'(0));
    applyStimulus(1'b1, 2'd0, 2, 100, -1, -1);
    checkOutput("fresh_nwr",   512'(capDin.size()), 512'(2));
    checkOutput("fresh_cyc0",  512'(cycAt(0)),      512'(20));
    checkOutput("fresh_cyc1",  512'(cycAt(1)),      512'(36));
    checkOutput("fresh_line1", dinAt(1),            expLine(16, 1'b0));
    checkOutput("fresh_done",  512'(doneCyc),       512'(37));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
